// File: rtl/io_timer_pkg.sv
// io_timer_pkg: shared constants for the memory-mapped interval timer.
//   - register offsets inside the 4-byte window
//   - CTRL / STATUS bit positions
//   - register and counter widths
package io_timer_pkg;

  localparam int unsigned REG_W = 8;   // CPU data bus / register width
  localparam int unsigned CNT_W = 16;  // count and reload width
  localparam int unsigned CTRL_W = 3;  // implemented CTRL bits

  localparam logic [1:0] OFF_CNT_LO = 2'd0;
  localparam logic [1:0] OFF_CNT_HI = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int unsigned CTRL_EN_BIT = 0;
  localparam int unsigned CTRL_AR_BIT = 1;
  localparam int unsigned CTRL_IE_BIT = 2;
  localparam int unsigned STAT_EXP_BIT = 0;

endpackage

// File: rtl/io_timer_tick_prescaler.sv
// tick_prescaler: divides clk into a one-cycle tick every PRESCALE+1 clocks.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   en    - count enable; while low the divider is held at 0
//   tick  - one-clk pulse when the divider reaches PRESCALE
module tick_prescaler #(
  parameter logic [7:0] PRESCALE = 8'd99
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  logic [7:0] pre_q;
  logic [7:0] pre_d;

  always_comb begin
    tick = en && (pre_q == PRESCALE);
    if (!en || tick) begin
      pre_d = 8'd0;
    end else begin
      pre_d = pre_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= 8'd0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/io_timer.sv
// io_timer: 16-bit down-counting interval timer on an 8-bit CPU bus.
// Register window at BASE..BASE+3:
//   0 CNT_LO  write: reload[7:0]   read: counter[7:0] (latches counter[15:8])
//   1 CNT_HI  write: reload[15:8]  read: latched high byte
//   2 CTRL    bit0 en, bit1 auto_reload, bit2 irq_en
//   3 STATUS  bit0 expired, write 1 to clear
// Ports:
//   clk, reset (async active-low)
//   AB[15:0] address, DO[7:0] write data, WE write enable
//   DI[7:0] registered read data, hit marks DI as timer data, irq level
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [15:0] BASE     = 16'hD000,
  parameter logic [7:0]  PRESCALE = 8'd99
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      AB,
  input  logic [REG_W-1:0] DO,
  input  logic             WE,
  output logic [REG_W-1:0] DI,
  output logic             hit,
  output logic             irq
);

  logic [CNT_W-1:0]  counter_q, counter_d;
  logic [CNT_W-1:0]  reload_q, reload_d;
  logic [REG_W-1:0]  snap_q, snap_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              expired_q, expired_d;
  logic [REG_W-1:0]  di_q, di_d;
  logic              hit_q, hit_d;
  logic              irq_q, irq_d;

  logic             sel, wr_en, rd_en, tick, set_exp;
  logic [1:0]       off;
  logic [CNT_W-1:0] eff_cnt;

  assign sel   = (AB[15:2] == BASE[15:2]);
  assign off   = AB[1:0];
  assign wr_en = sel & WE;
  assign rd_en = sel & ~WE;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q[CTRL_EN_BIT]),
    .tick  (tick)
  );

  // An expired counter parked at 0 in auto-reload mode restarts from the
  // reload value on the next tick; that tick also counts as one step, so
  // the period is exactly "reload" ticks. Without auto-reload a 0 simply
  // wraps to FFFF, which makes reload 0 mean 65536 ticks.
  assign eff_cnt = ((counter_q == '0) && ctrl_q[CTRL_AR_BIT]) ? reload_q : counter_q;

  always_comb begin
    counter_d = counter_q;
    reload_d  = reload_q;
    ctrl_d    = ctrl_q;
    expired_d = expired_q;
    set_exp   = 1'b0;

    if (wr_en && (off == OFF_CNT_LO)) begin
      reload_d[7:0] = DO;
    end
    if (wr_en && (off == OFF_CNT_HI)) begin
      reload_d[15:8] = DO;
      // Loading is suppressed while running so a reprogram cannot glitch
      // an interval in progress.
      if (!ctrl_q[CTRL_EN_BIT]) begin
        counter_d = {DO, reload_q[7:0]};
      end
    end

    // tick only fires while en is set, so it never collides with a load.
    if (tick) begin
      if (eff_cnt == CNT_W'(1)) begin
        counter_d = '0;
        set_exp   = 1'b1;
        if (!ctrl_q[CTRL_AR_BIT]) begin
          ctrl_d[CTRL_EN_BIT] = 1'b0;
        end
      end else begin
        counter_d = eff_cnt - CNT_W'(1);
      end
    end

    // CPU write lands after the hardware clear so software wins.
    if (wr_en && (off == OFF_CTRL)) begin
      ctrl_d = DO[CTRL_W-1:0];
    end

    if (wr_en && (off == OFF_STATUS) && DO[STAT_EXP_BIT]) begin
      expired_d = 1'b0;
    end
    if (set_exp) begin
      expired_d = 1'b1;
    end

    irq_d = expired_d & ctrl_d[CTRL_IE_BIT];
  end

  // Registered read port: one cycle of latency, like a synchronous RAM.
  always_comb begin
    di_d   = '0;
    hit_d  = rd_en;
    snap_d = snap_q;
    if (rd_en) begin
      case (off)
        OFF_CNT_LO: begin
          di_d   = counter_q[7:0];
          snap_d = counter_q[15:8];
        end
        OFF_CNT_HI: di_d = snap_q;
        OFF_CTRL:   di_d[CTRL_W-1:0] = ctrl_q;
        default:    di_d[STAT_EXP_BIT] = expired_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_q <= '0;
      reload_q  <= '0;
      snap_q    <= '0;
      ctrl_q    <= '0;
      expired_q <= 1'b0;
      di_q      <= '0;
      hit_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      reload_q  <= reload_d;
      snap_q    <= snap_d;
      ctrl_q    <= ctrl_d;
      expired_q <= expired_d;
      di_q      <= di_d;
      hit_q     <= hit_d;
      irq_q     <= irq_d;
    end
  end

  assign DI  = di_q;
  assign hit = hit_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed bench for io_timer with PRESCALE = 3 (tick every 4 clks).
// Bus ops are driven on the falling edge; the DUT acts on the next rising edge
// and results are sampled on the falling edge after that.
module tb_io_timer;

  localparam logic [15:0] A_LO   = 16'hD000;
  localparam logic [15:0] A_HI   = 16'hD001;
  localparam logic [15:0] A_CTRL = 16'hD002;
  localparam logic [15:0] A_STAT = 16'hD003;
  localparam logic [15:0] A_OUT  = 16'hD004;
  localparam logic [15:0] A_IDLE = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] AB = A_IDLE;
  logic [7:0]  DO = 8'h00;
  logic        WE = 1'b0;
  logic [7:0]  DI;
  logic        hit;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  io_timer #(.BASE(16'hD000), .PRESCALE(8'd3)) dut (
    .clk   (clk),
    .reset (reset),
    .AB    (AB),
    .DO    (DO),
    .WE    (WE),
    .DI    (DI),
    .hit   (hit),
    .irq   (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    AB = a; DO = d; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0; AB = A_IDLE; DO = 8'h00;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [7:0] d, output logic h);
    @(negedge clk);
    AB = a; WE = 1'b0;
    @(negedge clk);
    d = DI; h = hit; AB = A_IDLE;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic h;
    wait_neg(2);
    checks++;
    if ({irq, hit, DI} !== 10'd0) begin
      errors++; $display("FAIL reset_outputs got irq=%b hit=%b DI=%h want 0/0/00", irq, hit, DI);
    end
    reset = 1'b1;
    bus_rd(A_CTRL, d, h);
    checks++;
    if (d !== 8'h00 || h !== 1'b1) begin
      errors++; $display("FAIL reset_ctrl got %h hit=%b want 00 hit=1", d, h);
    end
    bus_rd(A_STAT, d, h);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", d); end
    bus_rd(A_LO, d, h);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_cnt_lo got %h want 00", d); end
  endtask

  task automatic test_oneshot();
    logic [7:0] d;
    logic h;
    int rise;
    rise = 0;
    bus_wr(A_LO, 8'h05);
    bus_wr(A_HI, 8'h00);
    bus_wr(A_CTRL, 8'h05);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (irq === 1'b1) begin rise = i; break; end
    end
    checks++;
    if (rise !== 20) begin errors++; $display("FAIL oneshot_latency got %0d want 20", rise); end
    bus_rd(A_STAT, d, h);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL oneshot_status got %h want 01", d); end
    bus_rd(A_CTRL, d, h);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL oneshot_en_cleared got %h want 04", d); end
    bus_rd(A_LO, d, h);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL oneshot_count got %h want 00", d); end
    bus_wr(A_STAT, 8'h01);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clear got %b want 0", irq); end
    bus_wr(A_CTRL, 8'h00);
  endtask

  task automatic test_auto_reload();
    int rise, t1, t2;
    rise = 0; t1 = 0; t2 = 0;
    bus_wr(A_LO, 8'h02);
    bus_wr(A_HI, 8'h00);
    bus_wr(A_CTRL, 8'h07);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (irq === 1'b1) begin rise = i; t1 = cyc; break; end
    end
    checks++;
    if (rise !== 8) begin errors++; $display("FAIL auto_first got %0d want 8", rise); end
    bus_wr(A_STAT, 8'h01);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL auto_irq_drop got %b want 0", irq); end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (irq === 1'b1) begin t2 = cyc; break; end
    end
    checks++;
    if (t2 - t1 !== 8) begin errors++; $display("FAIL auto_period got %0d want 8", t2 - t1); end
    bus_wr(A_CTRL, 8'h00);
    bus_wr(A_STAT, 8'h01);
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    logic h;
    bus_wr(A_LO, 8'h00);
    bus_wr(A_HI, 8'h00);
    bus_wr(A_CTRL, 8'h01);
    wait_neg(3);
    bus_wr(A_CTRL, 8'h00);
    bus_rd(A_LO, d, h);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL wrap_lo got %h want ff", d); end
    bus_rd(A_HI, d, h);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL wrap_hi got %h want ff", d); end
    bus_rd(A_STAT, d, h);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL wrap_status got %h want 00", d); end
  endtask

  task automatic test_snapshot();
    logic [7:0] d;
    logic h;
    bus_wr(A_LO, 8'hFF);
    bus_wr(A_HI, 8'h01);
    bus_rd(A_LO, d, h);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL snap_lo got %h want ff", d); end
    bus_wr(A_CTRL, 8'h01);
    wait_neg(9);
    bus_wr(A_CTRL, 8'h00);
    bus_rd(A_HI, d, h);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL snap_hi got %h want 01", d); end
    bus_rd(A_LO, d, h);
    checks++;
    if (d !== 8'hFD) begin errors++; $display("FAIL snap_live_lo got %h want fd", d); end
  endtask

  task automatic test_collisions();
    logic [7:0] d;
    logic h;
    // STATUS clear on the expiry edge: set wins
    bus_wr(A_LO, 8'h02);
    bus_wr(A_HI, 8'h00);
    bus_wr(A_CTRL, 8'h05);
    wait_neg(6);
    bus_wr(A_STAT, 8'h01);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL collide_irq got %b want 1", irq); end
    bus_rd(A_STAT, d, h);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL collide_status got %h want 01", d); end
    bus_wr(A_STAT, 8'h01);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL collide_clear got %b want 0", irq); end
    // CTRL write on the one-shot expiry edge: CPU value wins over en clear
    bus_wr(A_LO, 8'h02);
    bus_wr(A_HI, 8'h00);
    bus_wr(A_CTRL, 8'h01);
    wait_neg(6);
    bus_wr(A_CTRL, 8'h03);
    bus_rd(A_CTRL, d, h);
    checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL ctrl_priority got %h want 03", d); end
    bus_rd(A_STAT, d, h);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL ctrl_priority_status got %h want 01", d); end
    bus_wr(A_CTRL, 8'h00);
    bus_wr(A_STAT, 8'h01);
  endtask

  task automatic test_decode();
    bus_wr(A_CTRL, 8'h06);
    @(negedge clk);
    AB = A_CTRL; WE = 1'b0;
    @(negedge clk);
    checks++;
    if (DI !== 8'h06 || hit !== 1'b1) begin
      errors++; $display("FAIL decode_ctrl got %h hit=%b want 06 hit=1", DI, hit);
    end
    AB = A_OUT;
    @(negedge clk);
    checks++;
    if (DI !== 8'h00 || hit !== 1'b0) begin
      errors++; $display("FAIL decode_outside got %h hit=%b want 00 hit=0", DI, hit);
    end
    AB = A_CTRL; WE = 1'b1; DO = 8'h04;
    @(negedge clk);
    checks++;
    if (DI !== 8'h00 || hit !== 1'b0) begin
      errors++; $display("FAIL decode_write_cycle got %h hit=%b want 00 hit=0", DI, hit);
    end
    WE = 1'b0; DO = 8'h00;
    @(negedge clk);
    checks++;
    if (DI !== 8'h04 || hit !== 1'b1) begin
      errors++; $display("FAIL decode_readback got %h hit=%b want 04 hit=1", DI, hit);
    end
    AB = 16'hCFFF;
    @(negedge clk);
    checks++;
    if (DI !== 8'h00 || hit !== 1'b0) begin
      errors++; $display("FAIL decode_below got %h hit=%b want 00 hit=0", DI, hit);
    end
    AB = A_IDLE;
    bus_wr(A_CTRL, 8'h00);
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    logic h;
    bus_wr(A_LO, 8'h01);
    bus_wr(A_HI, 8'h00);
    bus_wr(A_CTRL, 8'h07);
    wait_neg(5);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL arst_pre_irq got %b want 1", irq); end
    AB = A_CTRL;
    @(negedge clk);
    checks++;
    if (DI !== 8'h07 || hit !== 1'b1) begin
      errors++; $display("FAIL arst_pre_read got %h hit=%b want 07 hit=1", DI, hit);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({irq, hit, DI} !== 10'd0) begin
      errors++; $display("FAIL arst_immediate got irq=%b hit=%b DI=%h want 0/0/00", irq, hit, DI);
    end
    wait_neg(3);
    checks++;
    if ({irq, hit, DI} !== 10'd0) begin
      errors++; $display("FAIL arst_hold got irq=%b hit=%b DI=%h want 0/0/00", irq, hit, DI);
    end
    reset = 1'b1;
    AB = A_IDLE;
    wait_neg(20);
    bus_rd(A_LO, d, h);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL arst_cnt_lo got %h want 00", d); end
    bus_rd(A_HI, d, h);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL arst_cnt_hi got %h want 00", d); end
    bus_rd(A_CTRL, d, h);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL arst_ctrl got %h want 00", d); end
    bus_rd(A_STAT, d, h);
    checks++;
    if (d !== 8'h00 || irq !== 1'b0) begin
      errors++; $display("FAIL arst_status got %h irq=%b want 00 irq=0", d, irq);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_wrap();
    test_snapshot();
    test_collisions();
    test_decode();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("FAIL timeout got cyc=%0d want finish before limit", cyc);
    $fatal(1);
  end

endmodule
